toggle_pulse_gen: RTL and testbench

TOGGLE_PULSE_GEN -- requirements
Module: toggle_pulse_gen

---
 rtl/toggle_pulse_gen.sv | 159 +++++++++++++++
 tb/tb_toggle_pulse_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/toggle_pulse_gen.sv
// Debounced push-button to single-cycle toggle pulse for a downstream T flip-flop.
// Optional auto-repeat while held: define TOGGLE_AUTOREPEAT_EN.
//
// state        | meaning
// -------------+----------------------------------------------------------
// IDLE         | button released and stable, waiting for a rising level
// PRESS_WAIT   | button seen high, counting stable cycles before accepting
// PRESSED      | press accepted, btn_level high, optional repeat running
// RELEASE_WAIT | button seen low, counting stable cycles before releasing
module toggle_pulse_gen #(
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_CYCLES = 16
) (
    input  logic CLK,
    input  logic rst,
    input  logic btn_in,
    input  logic en,
    output logic T,
    output logic btn_level
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (DB_CYCLES < 1) begin : g_bad_db
        $error("DB_CYCLES must be >= 1");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_rep
        $error("REPEAT_CYCLES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   t_q, t_d;
    logic                   level_q, level_d;
    logic                   btn_sync;
    logic                   entry_pulse;

`ifdef TOGGLE_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LOAD = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_q, rep_d;
`endif

    assign btn_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], btn_in};
        state_d     = state_q;
        cnt_d       = cnt_q;
        entry_pulse = 1'b0;
        t_d         = 1'b0;
`ifdef TOGGLE_AUTOREPEAT_EN
        rep_d       = REP_LOAD;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (btn_sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_MAX) begin
                    state_d     = PRESSED;
                    cnt_d       = '0;
                    entry_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
`ifdef TOGGLE_AUTOREPEAT_EN
                    // Period restarts on every entry, so the first repeat lands
                    // REPEAT_CYCLES after the entry pulse.
                    if (rep_q == '0) begin
                        t_d   = en;
                        rep_d = REP_LOAD;
                    end else begin
                        rep_d = rep_q - RW'(1);
                    end
`endif
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (entry_pulse) begin
            t_d = en;
        end
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            t_q     <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            level_q <= level_d;
        end
    end

`ifdef TOGGLE_AUTOREPEAT_EN
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    assign T         = t_q;
    assign btn_level = level_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Directed bench for toggle_pulse_gen at default parameters, both with and
// without TOGGLE_AUTOREPEAT_EN.
module tb_toggle_pulse_gen;

    logic CLK = 1'b0;
    logic rst;
    logic btn_in;
    logic en;
    logic T;
    logic btn_level;

    int n_tests = 0;
    int n_fail  = 0;
    int b2b     = 0;
    logic t_prev = 1'b0;

    int   t_edges[$];
    logic lvl_hist[0:255];

    typedef struct {
        int   hi;
        logic en_v;
        int   exp_pulses;
        int   exp_first_t;
        int   exp_first_lvl;
    } vec_t;

    vec_t vecs[7];

    toggle_pulse_gen dut (
        .CLK       (CLK),
        .rst       (rst),
        .btn_in    (btn_in),
        .en        (en),
        .T         (T),
        .btn_level (btn_level)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (T && t_prev) b2b++;
        t_prev = T;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // btn_in for edge e is pat[e-1]; samples are taken 1 time unit after each edge.
    task automatic run_seq(input logic [127:0] pat, input int window, input logic en_v);
        t_edges.delete();
        en = en_v;
        for (int e = 1; e <= window; e++) begin
            btn_in = (e <= 128) ? pat[e-1] : 1'b0;
            @(posedge CLK);
            #1;
            if (T) t_edges.push_back(e);
            lvl_hist[e] = btn_level;
        end
        btn_in = 1'b0;
    endtask

    task automatic idle(input int n);
        btn_in = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic logic [127:0] hi_pat(input int hi);
        logic [127:0] p;
        p = '0;
        for (int i = 0; i < hi && i < 128; i++) p[i] = 1'b1;
        return p;
    endfunction

    function automatic int first_lvl(input int window);
        for (int e = 1; e <= window; e++) if (lvl_hist[e]) return e;
        return 0;
    endfunction

    initial begin
        logic [127:0] pat;
        int exp_rep[$];
        int lc;

        vecs[0] = '{hi: 1,  en_v: 1'b1, exp_pulses: 0, exp_first_t: 0, exp_first_lvl: 0};
        vecs[1] = '{hi: 4,  en_v: 1'b1, exp_pulses: 0, exp_first_t: 0, exp_first_lvl: 0};
        vecs[2] = '{hi: 5,  en_v: 1'b1, exp_pulses: 1, exp_first_t: 7, exp_first_lvl: 7};
        vecs[3] = '{hi: 20, en_v: 1'b1, exp_pulses: 1, exp_first_t: 7, exp_first_lvl: 7};
        vecs[4] = '{hi: 5,  en_v: 1'b0, exp_pulses: 0, exp_first_t: 0, exp_first_lvl: 7};
        vecs[5] = '{hi: 8,  en_v: 1'b1, exp_pulses: 1, exp_first_t: 7, exp_first_lvl: 7};
        vecs[6] = '{hi: 12, en_v: 1'b0, exp_pulses: 0, exp_first_t: 0, exp_first_lvl: 7};

        // Reset held with the button already pressed.
        rst    = 1'b0;
        btn_in = 1'b1;
        en     = 1'b1;
        #1;
        check("rst_T_async", int'(T), 0);
        check("rst_lvl_async", int'(btn_level), 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            #1;
            check("rst_T_hold", int'(T), 0);
            check("rst_lvl_hold", int'(btn_level), 0);
        end
        rst = 1'b1;
        run_seq(hi_pat(12), 14, 1'b1);
        check("rst_rel_pulses", t_edges.size(), 1);
        check("rst_rel_first_T", (t_edges.size() > 0) ? t_edges[0] : 0, 7);
        check("rst_rel_first_lvl", first_lvl(14), 7);
        idle(20);

        for (int v = 0; v < 7; v++) begin
            run_seq(hi_pat(vecs[v].hi), vecs[v].hi + 20, vecs[v].en_v);
            check($sformatf("vec%0d_pulses", v), t_edges.size(), vecs[v].exp_pulses);
            check($sformatf("vec%0d_first_T", v),
                  (t_edges.size() > 0) ? t_edges[0] : 0, vecs[v].exp_first_t);
            check($sformatf("vec%0d_first_lvl", v), first_lvl(vecs[v].hi + 20),
                  vecs[v].exp_first_lvl);
            check($sformatf("vec%0d_end_lvl", v), int'(lvl_hist[vecs[v].hi + 20]), 0);
            idle(8);
        end

        // Bounce: high 3, low 1, high 2, then low.
        pat = '0;
        pat[5:0] = 6'b110111;
        run_seq(pat, 20, 1'b1);
        check("bounce_pulses", t_edges.size(), 0);
        check("bounce_lvl", first_lvl(20), 0);
        idle(8);

        // Release bounce: low for 2 cycles after acceptance, then high again.
        pat = hi_pat(20);
        pat[9]  = 1'b0;
        pat[10] = 1'b0;
        run_seq(pat, 40, 1'b1);
        check("relb_pulses", t_edges.size(), 1);
        check("relb_first_T", (t_edges.size() > 0) ? t_edges[0] : 0, 7);
        lc = 0;
        for (int e = 7; e <= 26; e++) lc += int'(lvl_hist[e]);
        check("relb_lvl_held", lc, 20);
        check("relb_lvl_before", int'(lvl_hist[6]), 0);
        check("relb_lvl_after", int'(lvl_hist[27]), 0);
        idle(8);

        // Long hold: auto-repeat behaviour.
`ifdef TOGGLE_AUTOREPEAT_EN
        exp_rep = '{7, 23, 39, 55};
`else
        exp_rep = '{7};
`endif
        run_seq(hi_pat(60), 80, 1'b1);
        check("hold_pulses", t_edges.size(), exp_rep.size());
        for (int i = 0; i < exp_rep.size(); i++)
            check($sformatf("hold_pulse%0d_edge", i),
                  (i < t_edges.size()) ? t_edges[i] : 0, exp_rep[i]);
        idle(8);

        // Reset while waiting for the press to settle.
        run_seq(hi_pat(30), 4, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_pw_T", int'(T), 0);
        check("mid_rst_pw_lvl", int'(btn_level), 0);
        btn_in = 1'b0;
        @(posedge CLK);
        #1;
        rst = 1'b1;
        idle(4);

        // Reset while pressed: level drops immediately, no clock needed.
        run_seq(hi_pat(30), 9, 1'b1);
        check("mid_rst_pr_pre_lvl", int'(lvl_hist[9]), 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_pr_T", int'(T), 0);
        check("mid_rst_pr_lvl", int'(btn_level), 0);
        @(posedge CLK);
        #1;
        rst = 1'b1;
        idle(10);
        check("post_rst_lvl", int'(btn_level), 0);

        check("no_back_to_back_T", b2b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
